// File: rtl/booth4_accumulator_if.sv
// Product stream from the booth4 multiplier into the group accumulator,
// plus the accumulator's result and status outputs.
interface booth4_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
);
    logic              done_sig;
    logic [PROD_W-1:0] product;
    logic [CNT_W-1:0]  len;
    logic              clear_sig;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              overflow;
    logic              busy;

    modport master (
        output done_sig, product, len, clear_sig,
        input  acc_out, acc_valid, overflow, busy
    );

    modport slave (
        input  done_sig, product, len, clear_sig,
        output acc_out, acc_valid, overflow, busy
    );
endinterface

// File: rtl/booth4_accumulator.sv
// Saturating group accumulator: sums len signed products per group and
// emits one registered result per group with a one-cycle valid pulse.
module booth4_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
) (
    input logic               clk,
    input logic               rst,
    booth4_accumulator_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;

    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W:0]   base_ext;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat;
    logic             clamp;

    // Adder and clamp; in IDLE the base is zero so the first term passes
    // through the same saturating path as every later term.
    always_comb begin
        len_eff  = (bus.len == '0) ? CNT_W'(1) : bus.len;
        cnt_next = cnt + CNT_W'(1);
        base_ext = (state == ACCUM) ? {acc[ACC_W-1], acc} : '0;
        prod_ext = {{(ACC_W+1-PROD_W){bus.product[PROD_W-1]}}, bus.product};
        sum      = base_ext + prod_ext;
        clamp    = (sum[ACC_W] != sum[ACC_W-1]);
        if (!clamp) begin
            sat = sum[ACC_W-1:0];
        end else if (sum[ACC_W]) begin
            sat = ACC_MIN;
        end else begin
            sat = ACC_MAX;
        end
    end

    // Group FSM with registered result, valid pulse, sticky overflow and busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            len_q         <= '0;
            bus.acc_out   <= '0;
            bus.acc_valid <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.acc_valid <= 1'b0;
            if (bus.clear_sig) begin
                state        <= IDLE;
                acc          <= '0;
                cnt          <= '0;
                bus.overflow <= 1'b0;
                bus.busy     <= 1'b0;
            end else if (bus.done_sig) begin
                if (clamp) begin
                    bus.overflow <= 1'b1;
                end
                if (state == IDLE) begin
                    len_q <= len_eff;
                    cnt   <= CNT_W'(1);
                    if (len_eff == CNT_W'(1)) begin
                        bus.acc_out   <= sat;
                        bus.acc_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else begin
                        acc      <= sat;
                        state    <= ACCUM;
                        bus.busy <= 1'b1;
                    end
                end else begin
                    if (cnt_next == len_q) begin
                        bus.acc_out   <= sat;
                        bus.acc_valid <= 1'b1;
                        acc           <= '0;
                        cnt           <= '0;
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                    end else begin
                        acc <= sat;
                        cnt <= cnt_next;
                    end
                end
            end
        end
    end
endmodule
